fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one 32-bit FIFO write port (WR/dataIn/EN, FULL, EMPTY, RD) between NUM_REQ producers. Supports multi-beat bursts: once a producer wins, it owns the port until its last beat is accepted. Keeps its own occupancy credit count from its writes and the consumer's reads, so it never issues a write the FIFO would drop. Sits between the producer blocks and the FIFO; the consumer drives FIFO RD directly.

---
 rtl/fifo_arb_pkg.sv | 8 +
 rtl/fifo_wr_arbiter_if.sv | 11 +
 rtl/rr_picker.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 74 +++++++
 tb/tb_fifo_wr_arbiter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write arbiters
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_e;
  localparam int DATA_W_DEF = 32;
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request/grant bus plus the FIFO write-side signals
interface fifo_wr_arbiter_if #(parameter int NUM_REQ = 4, parameter int DATA_W = 32);
  logic [NUM_REQ-1:0] req, req_last, gnt;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic fifo_wr, fifo_en, fifo_full, fifo_empty, fifo_rd;
  logic [DATA_W-1:0] fifo_data_in;
  modport master (input req, req_data, req_last, fifo_full, fifo_empty, fifo_rd,
                  output gnt, fifo_wr, fifo_en, fifo_data_in);
  modport slave (output req, req_data, req_last, fifo_full, fifo_empty, fifo_rd,
                 input gnt, fifo_wr, fifo_en, fifo_data_in);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search starting just after ptr_i
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [IW-1:0] c;
  // scan farthest to nearest so the closest requester after ptr_i wins
  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(ptr_i) + k) % N);
      if (req_i[c]) begin
        idx_o = c;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port, credit-limited
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  fifo_wr_arbiter_if.master bus,
  output logic [IW-1:0]     owner_o,
  output logic              busy_o
);
  state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, owner_q, owner_d, win, sel;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dat [NUM_REQ];
  logic win_v, space, acc, rd_ok, wr_q, en_q;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dat
    assign dat[g] = bus.req_data[g*DATA_W +: DATA_W];
  end
  rr_picker #(.N(NUM_REQ)) u_pick (
    .req_i  (bus.req),
    .ptr_i  (rr_q),
    .idx_o  (win),
    .valid_o(win_v)
  );
  // a burst owner keeps the port even when it drops req, so no interleaving
  always_comb begin
    space = enable_i && !bus.fifo_full && (occ_q < CNT_W'(DEPTH));
    sel = (state_q == IDLE) ? win : owner_q;
    acc = rst_n && space && ((state_q == IDLE) ? win_v : bus.req[owner_q]);
    rd_ok = bus.fifo_rd && !bus.fifo_empty && (occ_q != '0);
    state_d = state_q;
    rr_d = rr_q;
    owner_d = owner_q;
    if (acc) begin
      owner_d = sel;
      state_d = bus.req_last[sel] ? IDLE : BURST;
      rr_d = bus.req_last[sel] ? sel : rr_q;
    end
    occ_d = (acc && !rd_ok) ? occ_q + 1'b1 : (rd_ok && !acc) ? occ_q - 1'b1 : occ_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      occ_q <= '0;
      wr_q <= 1'b0;
      en_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      owner_q <= owner_d;
      occ_q <= occ_d;
      wr_q <= acc;
      en_q <= enable_i;
      data_q <= acc ? dat[sel] : data_q;
    end
  end
  assign bus.gnt = acc ? NUM_REQ'(1) << sel : '0;
  assign bus.fifo_wr = wr_q;
  assign bus.fifo_en = en_q;
  assign bus.fifo_data_in = data_q;
  assign owner_o = owner_q;
  assign busy_o = (state_q == BURST);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed plus random stimulus against a transaction-level arbiter model
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 32, D = 8;
  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0;
  logic [1:0] owner;
  logic busy;
  int errs = 0, checks = 0;
  int m_occ, m_rr, m_lock, m_owner;
  bit m_wr, m_en;
  logic [W-1:0] m_data;
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable_i(enable),
    .bus     (bus),
    .owner_o (owner),
    .busy_o  (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    m_occ = 0; m_rr = N - 1; m_lock = -1; m_owner = 0;
    m_wr = 0; m_en = 0; m_data = '0;
  endtask
  function automatic int exp_win();
    if (!rst_n || !enable || bus.fifo_full || m_occ >= D) return -1;
    if (m_lock >= 0) return bus.req[m_lock] ? m_lock : -1;
    for (int k = 1; k <= N; k++)
      if (bus.req[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction
  task automatic step();
    int w;
    logic [N-1:0] eg;
    #1;
    w = exp_win();
    eg = (w < 0) ? '0 : N'(1) << w;
    chk("gnt", bus.gnt, eg);
    chk("fifo_wr", bus.fifo_wr, m_wr);
    if (m_wr) chk("fifo_data", bus.fifo_data_in, m_data);
    chk("busy", busy, m_lock >= 0);
    chk("owner", owner, m_owner);
    chk("fifo_en", bus.fifo_en, m_en);
    m_wr = (w >= 0);
    if (w >= 0) begin
      m_data = bus.req_data[w*W +: W];
      m_owner = w;
      if (bus.req_last[w]) begin
        m_lock = -1;
        m_rr = w;
      end else m_lock = w;
      m_occ = m_occ + 1;
    end
    if (bus.fifo_rd && !bus.fifo_empty && m_occ > (w >= 0 ? 1 : 0)) m_occ = m_occ - 1;
    m_en = enable;
    @(negedge clk);
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic drain();
    bus.req = '0; bus.fifo_rd = 1'b1; bus.fifo_empty = 1'b0;
    steps(D + 1);
    bus.fifo_rd = 1'b0; bus.fifo_empty = 1'b1;
  endtask
  initial begin
    bus.req = '0; bus.req_last = '0; bus.req_data = '0;
    bus.fifo_full = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_rd = 1'b0;
    m_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    enable = 1'b1; bus.req = 4'b1111;
    step();
    m_reset();
    rst_n = 1'b1; bus.req = 4'b0001; bus.req_last = 4'b1111;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = i;
    step();
    bus.req = '0;
    step();
    bus.req = 4'b1111;
    steps(5);
    drain();
    bus.req = 4'b0100; bus.req_last = 4'b0000;
    step();
    bus.req = 4'b0101;
    step();
    enable = 1'b0;
    steps(3);
    enable = 1'b1; bus.req_last = 4'b0101;
    steps(3);
    drain();
    bus.req = 4'b0001; bus.req_last = 4'b0001;
    steps(9);
    bus.fifo_full = 1'b1;
    steps(2);
    bus.fifo_full = 1'b0; bus.fifo_rd = 1'b1; bus.fifo_empty = 1'b0;
    step();
    bus.fifo_rd = 1'b0; bus.fifo_empty = 1'b1;
    steps(3);
    drain();
    bus.req = 4'b0001;
    steps(4);
    bus.fifo_rd = 1'b1; bus.fifo_empty = 1'b0;
    step();
    bus.fifo_rd = 1'b0; bus.fifo_empty = 1'b1;
    steps(6);
    drain();
    bus.req = 4'b1111; bus.req_last = 4'b0000;
    steps(2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_wr", bus.fifo_wr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1; bus.req_last = 4'b1111;
    steps(3);
    for (int i = 0; i < 400; i++) begin
      bus.req = N'($urandom);
      bus.req_last = N'($urandom);
      bus.req_data = {$urandom, $urandom, $urandom, $urandom};
      enable = ($urandom_range(7) != 0);
      bus.fifo_rd = $urandom_range(1);
      bus.fifo_empty = ($urandom_range(3) == 0);
      bus.fifo_full = ($urandom_range(7) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
